// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-wide memory, using read-modify-write for stores.
// Build option: define LSU_MISALIGN_EN to split word-crossing accesses; otherwise they are rejected.
module load_store_unit #(
    parameter int unsigned N = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_width,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [N-1:0] lo_idx_q, lo_idx_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_data_q, lo_data_d;
    logic [31:0] hi_data_q, hi_data_d;
    logic        cross_q, cross_d;
    logic        err_q, err_d;

    // Request decode, evaluated on the incoming request while idle
    logic [2:0] req_size;
    logic       req_cross, lo_over, cross_err, req_err;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_cross = (3'(req_addr[1:0]) + req_size) > 3'd4;
        lo_over   = (req_addr[31:2] >> N) != 30'd0;
`ifdef LSU_MISALIGN_EN
        cross_err = req_cross && (((31'(req_addr[31:2]) + 31'd1) >> N) != 31'd0);
`else
        cross_err = req_cross;
`endif
        req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
               || (req_we && req_funct3[2]) || lo_over || cross_err;
    end

    // Load assembly and store merge over the {hi,lo} two-word window
    logic [N-1:0] hi_idx;
    logic [31:0]  load_word, load_ext;
    logic [3:0]   mask4;
    logic [7:0]   mask8;
    logic [63:0]  wdata_sh, old_win, merged;

    always_comb begin
        hi_idx    = lo_idx_q + N'(1);
        load_word = 32'({hi_data_q, lo_data_q} >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b100:  load_ext = {24'd0, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b101:  load_ext = {16'd0, load_word[15:0]};
            default: load_ext = load_word;
        endcase
        case (funct3_q[1:0])
            2'b00:   mask4 = 4'b0001;
            2'b01:   mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase
        mask8    = 8'(mask4) << off_q;
        wdata_sh = 64'(wdata_q) << {off_q, 3'b000};
        old_win  = {hi_data_q, lo_data_q};
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = mask8[i] ? wdata_sh[8*i +: 8] : old_win[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            lo_idx_q  <= '0;
            off_q     <= 2'd0;
            wdata_q   <= 32'd0;
            lo_data_q <= 32'd0;
            hi_data_q <= 32'd0;
            cross_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            lo_idx_q  <= lo_idx_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            lo_data_q <= lo_data_d;
            hi_data_q <= hi_data_d;
            cross_q   <= cross_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        lo_idx_d  = lo_idx_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        lo_data_d = lo_data_q;
        hi_data_d = hi_data_q;
        cross_d   = cross_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        mem_addr  = 32'd0;
        mem_width = 3'b010;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    lo_idx_d  = req_addr[N+1:2];
                    off_d     = req_addr[1:0];
                    wdata_d   = req_wdata;
                    lo_data_d = 32'd0;
                    hi_data_d = 32'd0;
                    err_d     = req_err;
                    cross_d   = req_cross && !req_err;
                    state_d   = req_err ? RESP : RD0;
                end
            end
            RD0: begin
                mem_addr  = 32'(lo_idx_q);
                lo_data_d = mem_rdata;
                state_d   = we_q ? WR0 : (cross_q ? RD1 : RESP);
            end
            WR0: begin
                mem_addr  = 32'(lo_idx_q);
                mem_we    = 1'b1;
                mem_wdata = merged[31:0];
                state_d   = cross_q ? RD1 : RESP;
            end
            RD1: begin
                mem_addr  = 32'(hi_idx);
                hi_data_d = mem_rdata;
                state_d   = we_q ? WR1 : RESP;
            end
            WR1: begin
                mem_addr  = 32'(hi_idx);
                mem_we    = 1'b1;
                mem_wdata = merged[63:32];
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'd0 : load_ext;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected responses, monitor checks them.
module tb_load_store_unit;
    localparam int unsigned N = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [2:0]  mem_width;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_width(mem_width), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model with a preload port so only one process writes it
    logic [31:0] mem [0:(1<<N)-1];
    logic        pl_en = 1'b0;
    logic [N-1:0] pl_idx = '0;
    logic [31:0] pl_val = 32'd0;
    int unsigned cyc = 0;
    int unsigned we_cnt = 0;

    assign mem_rdata = mem[mem_addr[N-1:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_we) begin
            mem[mem_addr[N-1:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                chk({e.name, "_lat"}, cyc - e.acc + 1, e.lat);
                chk({e.name, "_resp_mem_we"}, {31'd0, mem_we}, 32'd0);
            end
        end
    end

    task automatic preload(input int unsigned idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = N'(idx);
        pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic op(input string nm, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd,
                      input int unsigned e_lat, input int unsigned e_pulses);
        int unsigned w0;
        exp_t e;
        @(negedge clk);
        for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
        w0 = we_cnt;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        e.name = nm; e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.acc = cyc;
        sbq.push_back(e);
        for (int t = 0; t < 20 && sbq.size() != 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            chk({nm, "_timeout"}, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
        chk({nm, "_we_pulses"}, we_cnt - w0, e_pulses);
    endtask

    logic [31:0] exp_m0;
    int unsigned w_rst;
    logic        seen_we;

    initial begin
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("mem_width", {29'd0, mem_width}, 32'd2);

        preload(5, 32'h80FF_1234);
        preload(2, 32'hAABB_CCDD);
        preload(0, 32'h4433_2211);
        preload(1, 32'h8877_6655);
        preload((1 << N) - 1, 32'h0BAD_F00D);
        @(negedge clk);
        rst_n = 1'b1;

        op("lb_15",  1'b0, 3'b000, 32'h15, 32'd0, 1'b0, 32'h0000_0012, 2, 0);
        op("lbu_15", 1'b0, 3'b100, 32'h15, 32'd0, 1'b0, 32'h0000_0012, 2, 0);
        op("lb_17",  1'b0, 3'b000, 32'h17, 32'd0, 1'b0, 32'hFFFF_FF80, 2, 0);
        op("lbu_17", 1'b0, 3'b100, 32'h17, 32'd0, 1'b0, 32'h0000_0080, 2, 0);
        op("lb_16",  1'b0, 3'b000, 32'h16, 32'd0, 1'b0, 32'hFFFF_FFFF, 2, 0);
        op("lh_16",  1'b0, 3'b001, 32'h16, 32'd0, 1'b0, 32'hFFFF_80FF, 2, 0);
        op("lhu_16", 1'b0, 3'b101, 32'h16, 32'd0, 1'b0, 32'h0000_80FF, 2, 0);
        op("lw_14",  1'b0, 3'b010, 32'h14, 32'd0, 1'b0, 32'h80FF_1234, 2, 0);

        op("sh_0a", 1'b1, 3'b001, 32'h0A, 32'h0000_1234, 1'b0, 32'd0, 3, 1);
        chk("mem2_after_sh", mem[2], 32'h1234_CCDD);
        op("sb_09", 1'b1, 3'b000, 32'h09, 32'hA5A5_A577, 1'b0, 32'd0, 3, 1);
        chk("mem2_after_sb", mem[2], 32'h1234_77DD);
        op("lh_02", 1'b0, 3'b001, 32'h02, 32'd0, 1'b0, 32'h0000_4433, 2, 0);
        op("lw_top", 1'b0, 3'b010, 32'h3FFC, 32'd0, 1'b0, 32'h0BAD_F00D, 2, 0);

`ifdef LSU_MISALIGN_EN
        op("lw_03", 1'b0, 3'b010, 32'h03, 32'd0, 1'b0, 32'h7766_5544, 3, 0);
        op("lhu_03", 1'b0, 3'b101, 32'h03, 32'd0, 1'b0, 32'h0000_5544, 3, 0);
        op("sw_02", 1'b1, 3'b010, 32'h02, 32'hDEAD_BEEF, 1'b0, 32'd0, 5, 2);
        chk("mem0_after_sw", mem[0], 32'hBEEF_2211);
        chk("mem1_after_sw", mem[1], 32'h8877_DEAD);
        exp_m0 = 32'hBEEF_2211;
`else
        op("lw_03", 1'b0, 3'b010, 32'h03, 32'd0, 1'b1, 32'd0, 1, 0);
        op("lh_03", 1'b0, 3'b001, 32'h03, 32'd0, 1'b1, 32'd0, 1, 0);
        op("sw_02", 1'b1, 3'b010, 32'h02, 32'hDEAD_BEEF, 1'b1, 32'd0, 1, 0);
        chk("mem0_after_sw", mem[0], 32'h4433_2211);
        exp_m0 = 32'h4433_2211;
`endif
        op("lw_hi_over", 1'b0, 3'b010, 32'h3FFE, 32'd0, 1'b1, 32'd0, 1, 0);
        op("f3_011", 1'b0, 3'b011, 32'h14, 32'd0, 1'b1, 32'd0, 1, 0);
        op("f3_110", 1'b0, 3'b110, 32'h14, 32'd0, 1'b1, 32'd0, 1, 0);
        op("sw_2pn", 1'b1, 3'b010, 32'h4000, 32'h1234_5678, 1'b1, 32'd0, 1, 0);
        chk("mem0_after_sw_2pn", mem[0], exp_m0);
        op("sbu_bad", 1'b1, 3'b100, 32'h14, 32'h0000_0055, 1'b1, 32'd0, 1, 0);
        chk("mem5_after_sbu", mem[5], 32'h80FF_1234);
        op("lw_after_err", 1'b0, 3'b010, 32'h08, 32'd0, 1'b0, 32'h1234_77DD, 2, 0);

        // Reset asserted while the first write state is driving the memory
        @(negedge clk);
        w_rst = we_cnt;
        req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h1111_1111;
`ifdef LSU_MISALIGN_EN
        req_addr = 32'h02;
`else
        req_addr = 32'h00;
`endif
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen_we = 1'b0;
        for (int t = 0; t < 10 && !seen_we; t++) begin
            @(negedge clk);
            seen_we = mem_we;
        end
        chk("wr0_reached", {31'd0, seen_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_we_pulses", we_cnt - w_rst, 32'd0);
        chk("midrst_mem0", mem[0], exp_m0);
        chk("midrst_mem1_idle", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
